// File: rtl/qeciphy_gt_rx_aligner.sv
// Multi-lane 8b/10b RX comma alignment controller: slides each lane until K28.5 sits in byte 0, then tracks lock.
// Optional QECIPHY_ALIGN_STATS_EN adds per-lane relock counters on relock_cnt.
module qeciphy_gt_rx_aligner #(
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SLIDE_WAIT = 32,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned ERR_LIMIT  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              rx_reset_done,
  input  logic [NUM_CH*DATA_W-1:0]       rx_data,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   rx_charisk,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   rx_disperr,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   rx_notintable,
  output logic [NUM_CH-1:0]              rx_slide,
  output logic [NUM_CH-1:0]              rx_aligned,
  output logic                           all_aligned,
  output logic [NUM_CH-1:0]              align_fail
`ifdef QECIPHY_ALIGN_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]           relock_cnt
`endif
);

  localparam int unsigned BYTES     = DATA_W / 8;
  localparam int unsigned MAX_SLIDE = 10 * BYTES;
  localparam int unsigned GCW       = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT + 1)   : 1;
  localparam int unsigned ECW       = (ERR_LIMIT  > 1) ? $clog2(ERR_LIMIT + 1)  : 1;
  localparam int unsigned SCW       = $clog2(MAX_SLIDE + 1);
  localparam int unsigned WCW       = (SLIDE_WAIT > 1) ? $clog2(SLIDE_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    ST_WAIT_RST,
    ST_SEARCH,
    ST_SLIDE,
    ST_WAIT,
    ST_LOCKED
  } state_t;

  typedef enum logic [1:0] {
    CL_NONE,
    CL_GOOD,
    CL_MIS,
    CL_ERR
  } word_cls_t;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  kchar;
    logic [BYTES-1:0]  disperr;
    logic [BYTES-1:0]  notintable;
    logic              done;

    assign data       = rx_data[n*DATA_W +: DATA_W];
    assign kchar      = rx_charisk[n*BYTES +: BYTES];
    assign disperr    = rx_disperr[n*BYTES +: BYTES];
    assign notintable = rx_notintable[n*BYTES +: BYTES];
    assign done       = rx_reset_done[n];

    word_cls_t         cls;
    logic              found;

    state_t            state_q, state_d;
    logic [GCW-1:0]    good_cnt_q, good_cnt_d;
    logic [ECW-1:0]    err_cnt_q, err_cnt_d;
    logic [SCW-1:0]    slide_cnt_q, slide_cnt_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic              slide_q, slide_d;
    logic              aligned_q, aligned_d;
    logic              fail_q, fail_d;
    logic              relock_evt;

    // Lowest comma byte wins; any code error overrides the comma position.
    always_comb begin
      cls   = CL_NONE;
      found = 1'b0;
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (!found && kchar[b] && (data[b*8 +: 8] == 8'hBC)) begin
          found = 1'b1;
          cls   = (b == 0) ? CL_GOOD : CL_MIS;
        end
      end
      if ((|disperr) || (|notintable)) begin
        cls = CL_ERR;
      end
    end

    always_comb begin
      state_d     = state_q;
      good_cnt_d  = good_cnt_q;
      err_cnt_d   = err_cnt_q;
      slide_cnt_d = slide_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      slide_d     = 1'b0;
      aligned_d   = aligned_q;
      fail_d      = 1'b0;
      relock_evt  = 1'b0;

      if (!done) begin
        state_d     = ST_WAIT_RST;
        good_cnt_d  = '0;
        err_cnt_d   = '0;
        slide_cnt_d = '0;
        wait_cnt_d  = '0;
        aligned_d   = 1'b0;
      end else begin
        unique case (state_q)
          ST_WAIT_RST: begin
            state_d   = ST_SEARCH;
            aligned_d = 1'b0;
          end
          ST_SEARCH: begin
            unique case (cls)
              CL_GOOD: begin
                if (good_cnt_q >= GCW'(LOCK_CNT - 1)) begin
                  state_d     = ST_LOCKED;
                  aligned_d   = 1'b1;
                  good_cnt_d  = '0;
                  slide_cnt_d = '0;
                end else begin
                  good_cnt_d = good_cnt_q + 1'b1;
                end
              end
              CL_MIS: begin
                good_cnt_d = '0;
                state_d    = ST_SLIDE;
                slide_d    = 1'b1;
              end
              CL_ERR: begin
                good_cnt_d = '0;
              end
              default: ;
            endcase
          end
          ST_SLIDE: begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
            if (slide_cnt_q >= SCW'(MAX_SLIDE - 1)) begin
              slide_cnt_d = '0;
              fail_d      = 1'b1;
            end else begin
              slide_cnt_d = slide_cnt_q + 1'b1;
            end
          end
          ST_WAIT: begin
            if (wait_cnt_q >= WCW'(SLIDE_WAIT - 1)) begin
              state_d    = ST_SEARCH;
              wait_cnt_d = '0;
            end else begin
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (cls == CL_GOOD) begin
              err_cnt_d = '0;
            end else if ((cls == CL_MIS) || (cls == CL_ERR)) begin
              if (err_cnt_q >= ECW'(ERR_LIMIT - 1)) begin
                state_d    = ST_SEARCH;
                aligned_d  = 1'b0;
                err_cnt_d  = '0;
                good_cnt_d = '0;
                relock_evt = 1'b1;
              end else begin
                err_cnt_d = err_cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_d   = ST_WAIT_RST;
            aligned_d = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= ST_WAIT_RST;
        good_cnt_q  <= '0;
        err_cnt_q   <= '0;
        slide_cnt_q <= '0;
        wait_cnt_q  <= '0;
        slide_q     <= 1'b0;
        aligned_q   <= 1'b0;
        fail_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        good_cnt_q  <= good_cnt_d;
        err_cnt_q   <= err_cnt_d;
        slide_cnt_q <= slide_cnt_d;
        wait_cnt_q  <= wait_cnt_d;
        slide_q     <= slide_d;
        aligned_q   <= aligned_d;
        fail_q      <= fail_d;
      end
    end

    assign rx_slide[n]   = slide_q;
    assign rx_aligned[n] = aligned_q;
    assign align_fail[n] = fail_q;

`ifdef QECIPHY_ALIGN_STATS_EN
    logic [15:0] relock_q, relock_d;

    always_comb begin
      relock_d = relock_q;
      if (relock_evt && (relock_q != '1)) begin
        relock_d = relock_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        relock_q <= '0;
      end else begin
        relock_q <= relock_d;
      end
    end

    assign relock_cnt[n*16 +: 16] = relock_q;
`else
    logic unused_relock;
    assign unused_relock = relock_evt;
`endif
  end

  logic all_aligned_q, all_aligned_d;

  always_comb begin
    all_aligned_d = &rx_aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_aligned_q <= 1'b0;
    end else begin
      all_aligned_q <= all_aligned_d;
    end
  end

  assign all_aligned = all_aligned_q;

endmodule

// File: tb/tb_qeciphy_gt_rx_aligner.sv
// Randomized scoreboard bench for qeciphy_gt_rx_aligner: a lane-level reference model plus a simple GT offset model.
module tb_qeciphy_gt_rx_aligner;

  localparam int NCH    = 4;
  localparam int DW     = 32;
  localparam int BY     = DW / 8;
  localparam int SW     = 6;
  localparam int LC     = 5;
  localparam int EL     = 3;
  localparam int NSLIDE = 10 * BY;
  localparam int EPOCHS = 6;
  localparam int EPLEN  = 700;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    rx_reset_done;
  logic [NCH*DW-1:0] rx_data;
  logic [NCH*BY-1:0] rx_charisk;
  logic [NCH*BY-1:0] rx_disperr;
  logic [NCH*BY-1:0] rx_notintable;
  logic [NCH-1:0]    rx_slide;
  logic [NCH-1:0]    rx_aligned;
  logic              all_aligned;
  logic [NCH-1:0]    align_fail;
`ifdef QECIPHY_ALIGN_STATS_EN
  logic [NCH*16-1:0] relock_cnt;
`endif

  always #5 clk = ~clk;

  qeciphy_gt_rx_aligner #(
    .NUM_CH    (NCH),
    .DATA_W    (DW),
    .SLIDE_WAIT(SW),
    .LOCK_CNT  (LC),
    .ERR_LIMIT (EL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_reset_done(rx_reset_done),
    .rx_data      (rx_data),
    .rx_charisk   (rx_charisk),
    .rx_disperr   (rx_disperr),
    .rx_notintable(rx_notintable),
    .rx_slide     (rx_slide),
    .rx_aligned   (rx_aligned),
    .all_aligned  (all_aligned),
    .align_fail   (align_fail)
`ifdef QECIPHY_ALIGN_STATS_EN
    ,
    .relock_cnt   (relock_cnt)
`endif
  );

  typedef struct {
    logic [NCH-1:0]    slide;
    logic [NCH-1:0]    aligned;
    logic [NCH-1:0]    fail;
    logic              all;
    logic [NCH*16-1:0] rel;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: per lane a handful of counters; busy counts the remaining slide+quiet cycles.
  bit m_inrst[NCH];
  bit m_lock[NCH];
  int m_busy[NCH];
  int m_good[NCH];
  int m_errs[NCH];
  int m_slides[NCH];
  int m_rel[NCH];
  bit m_slide[NCH];
  bit m_al[NCH];
  bit m_fail[NCH];
  bit m_all;

  // GT stimulus model
  int ofs[NCH];
  int mode[NCH];
  int burst[NCH];
  int rst_hold[NCH];
  int cls[NCH];
  bit rst_drops_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [DW-1:0] d, input logic [BY-1:0] k,
                                  input logic [BY-1:0] e, input logic [BY-1:0] nt);
    if ((e | nt) != '0) return 3;
    for (int b = 0; b < BY; b++) begin
      if (k[b] && d[b*8 +: 8] == 8'hBC) return (b == 0) ? 1 : 2;
    end
    return 0;
  endfunction

  task automatic model_lane_reset(input int n);
    m_inrst[n]  = 1'b1;
    m_lock[n]   = 1'b0;
    m_busy[n]   = 0;
    m_good[n]   = 0;
    m_errs[n]   = 0;
    m_slides[n] = 0;
    m_slide[n]  = 1'b0;
    m_al[n]     = 1'b0;
    m_fail[n]   = 1'b0;
  endtask

  task automatic model_full_reset();
    for (int n = 0; n < NCH; n++) begin
      model_lane_reset(n);
      m_rel[n] = 0;
    end
    m_all = 1'b0;
  endtask

  task automatic model_step();
    bit prev_all;
    prev_all = 1'b1;
    for (int n = 0; n < NCH; n++) prev_all = prev_all & m_al[n];
    for (int n = 0; n < NCH; n++) begin
      m_fail[n]  = 1'b0;
      m_slide[n] = 1'b0;
      if (!rx_reset_done[n]) begin
        model_lane_reset(n);
      end else if (m_inrst[n]) begin
        m_inrst[n] = 1'b0;
      end else if (m_busy[n] > 0) begin
        if (m_busy[n] == SW + 1) begin
          m_slides[n]++;
          if (m_slides[n] == NSLIDE) begin
            m_fail[n]   = 1'b1;
            m_slides[n] = 0;
          end
        end
        m_busy[n]--;
      end else if (m_lock[n]) begin
        if (cls[n] == 1) begin
          m_errs[n] = 0;
        end else if (cls[n] >= 2) begin
          m_errs[n]++;
          if (m_errs[n] == EL) begin
            m_lock[n] = 1'b0;
            m_al[n]   = 1'b0;
            m_errs[n] = 0;
            m_good[n] = 0;
            if (m_rel[n] < 65535) m_rel[n]++;
          end
        end
      end else begin
        if (cls[n] == 1) begin
          m_good[n]++;
          if (m_good[n] == LC) begin
            m_lock[n]   = 1'b1;
            m_al[n]     = 1'b1;
            m_good[n]   = 0;
            m_slides[n] = 0;
          end
        end else if (cls[n] == 2) begin
          m_good[n]  = 0;
          m_busy[n]  = SW + 1;
          m_slide[n] = 1'b1;
          // GT shifts the comma by one byte per slide; stuck lanes never reach byte 0
          if (mode[n] == 2) ofs[n] = 1 + (ofs[n] % (BY - 1));
          else ofs[n] = (ofs[n] + 1) % BY;
        end else if (cls[n] == 3) begin
          m_good[n] = 0;
        end
      end
    end
    m_all = prev_all;
  endtask

  task automatic push_expected();
    exp_t e;
    for (int n = 0; n < NCH; n++) begin
      e.slide[n]          = m_slide[n];
      e.aligned[n]        = m_al[n];
      e.fail[n]           = m_fail[n];
      e.rel[n*16 +: 16]   = 16'(m_rel[n]);
    end
    e.all = m_all;
    sb.push_back(e);
  endtask

  task automatic drive_inputs();
    logic [DW-1:0] d;
    logic [BY-1:0] k, e, nt;
    int j;
    for (int n = 0; n < NCH; n++) begin
      if (rst_hold[n] > 0) begin
        rst_hold[n]--;
        rx_reset_done[n] = 1'b0;
      end else if (rst_drops_en && $urandom_range(0, 999) < 3) begin
        rst_hold[n]      = $urandom_range(0, 3);
        rx_reset_done[n] = 1'b0;
      end else begin
        rx_reset_done[n] = 1'b1;
      end
      d  = {$urandom, $urandom} >> (64 - DW);
      k  = '0;
      e  = '0;
      nt = '0;
      if ($urandom_range(0, 9) == 0) begin
        j = $urandom_range(0, BY - 1);
        k[j] = 1'b1;
        d[j*8 +: 8] = 8'h1C;
      end
      if ($urandom_range(0, 9) != 0) begin
        d[ofs[n]*8 +: 8] = 8'hBC;
        k[ofs[n]] = 1'b1;
      end
      if (mode[n] != 2 && $urandom_range(0, 99) < 4) begin
        j = $urandom_range(0, BY - 1);
        d[j*8 +: 8] = 8'hBC;
        k[j] = 1'b1;
      end
      if (burst[n] > 0) begin
        burst[n]--;
        e[$urandom_range(0, BY - 1)] = 1'b1;
      end else if (mode[n] == 1 && $urandom_range(0, 99) < 8) begin
        if ($urandom_range(0, 1) == 0) e[$urandom_range(0, BY - 1)] = 1'b1;
        else nt[$urandom_range(0, BY - 1)] = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        burst[n] = $urandom_range(0, EL - 1);
        nt[$urandom_range(0, BY - 1)] = 1'b1;
      end
      rx_data[n*DW +: DW]       = d;
      rx_charisk[n*BY +: BY]    = k;
      rx_disperr[n*BY +: BY]    = e;
      rx_notintable[n*BY +: BY] = nt;
      cls[n] = classify(d, k, e, nt);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_slide"},    64'(rx_slide),    64'd0);
    chk({tag, "_rx_aligned"},  64'(rx_aligned),  64'd0);
    chk({tag, "_all_aligned"}, 64'(all_aligned), 64'd0);
    chk({tag, "_align_fail"},  64'(align_fail),  64'd0);
`ifdef QECIPHY_ALIGN_STATS_EN
    chk({tag, "_relock_cnt"},  64'(relock_cnt),  64'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rx_slide",    64'(rx_slide),    64'(e.slide));
      chk("rx_aligned",  64'(rx_aligned),  64'(e.aligned));
      chk("all_aligned", 64'(all_aligned), 64'(e.all));
      chk("align_fail",  64'(align_fail),  64'(e.fail));
`ifdef QECIPHY_ALIGN_STATS_EN
      chk("relock_cnt",  64'(relock_cnt),  64'(e.rel));
`endif
    end
  end

  initial begin
    bit did_async;
    bit any_busy;
    did_async     = 1'b0;
    rst_drops_en  = 1'b0;
    rx_reset_done = '0;
    rx_data       = '0;
    rx_charisk    = '0;
    rx_disperr    = '0;
    rx_notintable = '0;
    for (int n = 0; n < NCH; n++) begin
      ofs[n] = 0; mode[n] = 0; burst[n] = 0; rst_hold[n] = 0; cls[n] = 0;
    end
    model_full_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #1;
    rst_n = 1'b1;

    for (int ep = 0; ep < EPOCHS; ep++) begin
      rst_drops_en = (ep == 2) || (ep == 4);
      for (int n = 0; n < NCH; n++) begin
        mode[n] = (ep == 0) ? 0 : $urandom_range(0, 1);
        if ((ep == 1 && n == 0) || (ep == 3 && n == 1) || (ep == 5 && n == 2)) mode[n] = 2;
        ofs[n] = (mode[n] == 2) ? $urandom_range(1, BY - 1) : $urandom_range(0, BY - 1);
      end
      for (int cyc = 0; cyc < EPLEN; cyc++) begin
        drive_inputs();
        @(posedge clk);
        model_step();
        push_expected();
        #2;
        any_busy = 1'b0;
        for (int n = 0; n < NCH; n++) if (m_busy[n] > 0) any_busy = 1'b1;
        if (ep == 3 && !did_async && cyc > 300 && any_busy) begin
          did_async = 1'b1;
          @(negedge clk);
          #2;
          rst_n = 1'b0;
          #1;
          check_all_zero("async_rst");
          @(posedge clk);
          #1;
          check_all_zero("held_rst");
          model_full_reset();
          #1;
          rst_n = 1'b1;
        end
      end
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
